// File: rtl/uart_pkg.sv
// Shared UART constants: data width and the default FIFO geometry used by both
// the transmit and receive FIFOs.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int FIFO_DEPTH      = 16;
    localparam int FIFO_AW         = 4;
    localparam int FIFO_AFULL_LVL  = 12;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bus-side/transmitter-side signal bundle of the transmit FIFO; the master side
// pushes bytes and strobes pops, the slave side is the FIFO itself.
interface uart_tx_fifo_if #(
    parameter int AW = uart_pkg::FIFO_AW
) ();
    import uart_pkg::*;

    logic                   wr_en;
    logic [UART_DATA_W-1:0] wr_data;
    logic                   rd_n;
    logic [UART_DATA_W-1:0] rd_data;
    logic                   empty;
    logic                   full;
    logic                   afull;
    logic [AW:0]            level;
    logic                   overflow;
    logic                   overflow_clr;

    modport master (
        output wr_en, wr_data, rd_n, overflow_clr,
        input  rd_data, empty, full, afull, level, overflow
    );

    modport slave (
        input  wr_en, wr_data, rd_n, overflow_clr,
        output rd_data, empty, full, afull, level, overflow
    );

endinterface

// File: rtl/uart_fifo_ram.sv
// DEPTH x 8 single-clock RAM with one write port and one registered read port.
// A same-address read and write returns the old contents (read before write).
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = FIFO_AW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [UART_DATA_W-1:0] wdata,
    input  logic                   re,
    input  logic [AW-1:0]          raddr,
    output logic [UART_DATA_W-1:0] rdata
);

    logic [UART_DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset so the array still maps onto block RAM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO: bus writes push, the transmitter pops with an active-low
// strobe; level, almost-full and sticky overflow feed the status register.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int AW        = FIFO_AW,
    parameter int AFULL_LVL = FIFO_AFULL_LVL
) (
    input  logic           CLK,
    input  logic           RESET_N,
    uart_tx_fifo_if.slave  bus
);

    localparam int LW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] next_level;
    logic          pop_ok;
    logic          push_ok;
    logic          drop;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // still accepted when paired with a real pop; an empty FIFO never falls through.
    always_comb begin
        pop_ok     = 1'b0;
        push_ok    = 1'b0;
        drop       = 1'b0;
        next_level = bus.level;
        pop_ok     = !bus.rd_n && !bus.empty;
        push_ok    = bus.wr_en && (!bus.full || pop_ok);
        drop       = bus.wr_en && !push_ok;
        next_level = bus.level + LW'(push_ok) - LW'(pop_ok);
    end

    uart_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (CLK),
        .rst_n (RESET_N),
        .we    (push_ok && RESET_N),
        .waddr (wr_ptr),
        .wdata (bus.wr_data),
        .re    (pop_ok && RESET_N),
        .raddr (rd_ptr),
        .rdata (bus.rd_data)
    );

    // Flags are computed from the next level so they always agree with level.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            bus.level    <= '0;
            bus.empty    <= 1'b1;
            bus.full     <= 1'b0;
            bus.afull    <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            bus.level <= next_level;
            bus.empty <= (next_level == '0);
            bus.full  <= (next_level == LW'(DEPTH));
            bus.afull <= (next_level >= LW'(AFULL_LVL));
            if (drop) begin
                bus.overflow <= 1'b1;
            end else if (bus.overflow_clr) begin
                bus.overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a queue-based model is compared against
// the DUT every cycle, plus directed literal checks along the stimulus sequence.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    logic CLK;
    logic RESET_N;
    int   total;
    int   bad;

    uart_tx_fifo_if #(.AW(4)) bus ();

    uart_tx_fifo #(
        .DEPTH     (DEPTH),
        .AW        (4),
        .AFULL_LVL (AFULL)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural model: a plain queue of bytes plus the last popped byte.
    byte unsigned q[$];
    byte unsigned m_rd;
    bit           m_ovf;
    bit           model_ready;
    bit           m_pop;
    bit           m_push;

    initial begin
        model_ready = 1'b0;
        m_rd        = 8'h00;
        m_ovf       = 1'b0;
    end

    always @(posedge CLK) begin
        if (!RESET_N) begin
            q.delete();
            m_rd        = 8'h00;
            m_ovf       = 1'b0;
            model_ready = 1'b1;
        end else if (model_ready) begin
            m_pop  = !bus.rd_n && (q.size() != 0);
            m_push = bus.wr_en && ((q.size() < DEPTH) || m_pop);
            if (m_pop) m_rd = q.pop_front();
            if (m_push) q.push_back(bus.wr_data);
            if (bus.wr_en && !m_push) m_ovf = 1'b1;
            else if (bus.overflow_clr) m_ovf = 1'b0;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (model_ready) begin
            check_output("model rd_data", 32'(bus.rd_data), 32'(m_rd));
            check_output("model level", 32'(bus.level), 32'(q.size()));
            check_output("model empty", 32'(bus.empty), 32'(q.size() == 0));
            check_output("model full", 32'(bus.full), 32'(q.size() == DEPTH));
            check_output("model afull", 32'(bus.afull), 32'(q.size() >= AFULL));
            check_output("model overflow", 32'(bus.overflow), 32'(m_ovf));
        end
    end

    task automatic apply_stimulus(input logic rst_n, input logic w, input logic [7:0] d,
                                  input logic r_n, input logic clr);
        RESET_N          = rst_n;
        bus.wr_en        = w;
        bus.wr_data      = d;
        bus.rd_n         = r_n;
        bus.overflow_clr = clr;
        @(posedge CLK);
        #1;
        RESET_N          = 1'b1;
        bus.wr_en        = 1'b0;
        bus.wr_data      = 8'h00;
        bus.rd_n         = 1'b1;
        bus.overflow_clr = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_b;
        total = 0;
        bad   = 0;
        RESET_N = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_data = 8'h00;
        bus.rd_n = 1'b1;
        bus.overflow_clr = 1'b0;

        // Reset, then idle and an ignored pop on an empty FIFO.
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check_output("reset level", 32'(bus.level), 32'd0);
        check_output("reset empty", 32'(bus.empty), 32'd1);
        check_output("reset rd_data", 32'(bus.rd_data), 32'h00);
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_output("empty pop level", 32'(bus.level), 32'd0);
        check_output("empty pop rd_data", 32'(bus.rd_data), 32'h00);
        check_output("empty pop overflow", 32'(bus.overflow), 32'd0);

        // Two pushes then two pops.
        apply_stimulus(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b1, 8'h3C, 1'b1, 1'b0);
        check_output("two pushed level", 32'(bus.level), 32'd2);
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_output("first pop data", 32'(bus.rd_data), 32'hA5);
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_output("second pop data", 32'(bus.rd_data), 32'h3C);
        check_output("drained empty", 32'(bus.empty), 32'd1);

        // Fill to full, watching afull and full thresholds.
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, 1'b1, 8'(i), 1'b1, 1'b0);
            if (i == 10) check_output("afull below threshold", 32'(bus.afull), 32'd0);
            if (i == 11) check_output("afull at threshold", 32'(bus.afull), 32'd1);
            if (i == 14) check_output("full at 15", 32'(bus.full), 32'd0);
            if (i == 15) check_output("full at 16", 32'(bus.full), 32'd1);
        end
        // Dropped push with a simultaneous clear: the drop wins.
        apply_stimulus(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
        check_output("drop sets overflow", 32'(bus.overflow), 32'd1);
        check_output("drop keeps level", 32'(bus.level), 32'd16);
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        check_output("overflow cleared", 32'(bus.overflow), 32'd0);

        // Push and pop together while full.
        apply_stimulus(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        check_output("full push+pop data", 32'(bus.rd_data), 32'h00);
        check_output("full push+pop level", 32'(bus.level), 32'd16);
        check_output("full push+pop overflow", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
            exp_b = (i == 15) ? 8'h77 : 8'(i + 1);
            check_output("drain order", 32'(bus.rd_data), 32'(exp_b));
        end

        // Push into empty with a pop in the same cycle: no fall-through.
        apply_stimulus(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        check_output("no fall-through level", 32'(bus.level), 32'd1);
        check_output("no fall-through data", 32'(bus.rd_data), 32'h77);
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_output("after fall-through pop", 32'(bus.rd_data), 32'h55);

        // Interleaved traffic forcing pointer wrap, then reset mid-stream.
        for (int i = 0; i < 40; i++) begin
            apply_stimulus(1'b1, 1'b1, 8'(i * 7 + 3), (i % 3 == 0), 1'b0);
            if (i == 1) check_output("wrap first pop", 32'(bus.rd_data), 32'h03);
        end
        check_output("pre-reset level", 32'(bus.level), 32'd14);
        apply_stimulus(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
        check_output("mid reset level", 32'(bus.level), 32'd0);
        check_output("mid reset empty", 32'(bus.empty), 32'd1);
        check_output("mid reset overflow", 32'(bus.overflow), 32'd0);
        check_output("mid reset rd_data", 32'(bus.rd_data), 32'h00);
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_output("post reset pop ignored", 32'(bus.level), 32'd0);

        @(posedge CLK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
